// File: rtl/lia_sram_if.sv
// lia_sram_if: asynchronous SRAM write-port bundle between the logger (master) and the memory (slave).
interface lia_sram_if;
  logic [19:0] addr;
  logic [15:0] dq_out;
  logic dq_oe, ce_n, we_n, oe_n, lb_n, ub_n;
  modport master(output addr, dq_out, dq_oe, ce_n, we_n, oe_n, lb_n, ub_n);
  modport slave(input addr, dq_out, dq_oe, ce_n, we_n, oe_n, lb_n, ub_n);
endinterface

// File: rtl/lia_sram_logger.sv
// lia_sram_logger: 8-channel lock-in sample logger writing tagged records into an SRAM ring.
// Define LIA_LOG_TSTAMP_EN to append a 16-bit load timestamp as a 4th record word.
module lia_sram_logger #(
  parameter int DEPTH_WORDS = 1048560,
  parameter int WE_CYCLES = 2
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic [7:0] ch_valid,
  input  logic [127:0] ch_x,
  input  logic [127:0] ch_y,
  input  logic log_enable,
  input  logic log_clear,
  lia_sram_if.master sram,
  output logic [19:0] wr_ptr,
  output logic wrapped,
  output logic [15:0] overflow_count,
  output logic busy
);
`ifdef LIA_LOG_TSTAMP_EN
  localparam int W = 4;
`else
  localparam int W = 3;
`endif
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] full_q, full_d;
  logic [15:0] x_q [8];
  logic [15:0] x_d [8];
  logic [15:0] y_q [8];
  logic [15:0] y_d [8];
  logic [2:0] last_q, last_d, g_q, g_d, gnt;
  logic [1:0] widx_q, widx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [11:0] seq_q, seq_d;
  logic [19:0] ptr_q, ptr_d;
  logic wrap_q, wrap_d, clrp_q, clrp_d;
  logic [15:0] ovf_q, ovf_d;
  logic clr, rel_last;
  logic [3:0] ndrop;
  logic [16:0] ovf_sum;
  logic [15:0] word;
`ifdef LIA_LOG_TSTAMP_EN
  logic [15:0] ts_q, ts_d;
  logic [15:0] tcap_q [8];
  logic [15:0] tcap_d [8];
`endif
  always_comb begin
    gnt = last_q;
    for (int k = 7; k >= 0; k--)
      if (full_q[last_q + 3'(k + 1)]) gnt = last_q + 3'(k + 1);
    state_d = state_q;
    g_d = g_q;
    last_d = last_q;
    widx_d = widx_q;
    cnt_d = cnt_q;
    seq_d = seq_q;
    ptr_d = ptr_q;
    wrap_d = wrap_q;
    clrp_d = clrp_q | log_clear;
    clr = 1'b0;
    rel_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (clrp_q || log_clear) begin
          clr = 1'b1;
          clrp_d = 1'b0;
          seq_d = '0;
          ptr_d = '0;
          wrap_d = 1'b0;
        end else if (log_enable && |full_q) begin
          state_d = SETUP;
          g_d = gnt;
          last_d = gnt;
          widx_d = '0;
        end
      end
      SETUP: begin
        state_d = PULSE;
        cnt_d = '0;
      end
      PULSE: begin
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(WE_CYCLES - 1)) ? HOLD : PULSE;
      end
      default: begin
        ptr_d = (ptr_q == 20'(DEPTH_WORDS - 1)) ? '0 : ptr_q + 20'd1;
        wrap_d = wrap_q | (ptr_q == 20'(DEPTH_WORDS - 1));
        rel_last = (widx_q == 2'(W - 1));
        state_d = rel_last ? IDLE : SETUP;
        widx_d = rel_last ? widx_q : widx_q + 2'd1;
        seq_d = rel_last ? seq_q + 12'd1 : seq_q;
      end
    endcase
    ndrop = '0;
    for (int i = 0; i < 8; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
`ifdef LIA_LOG_TSTAMP_EN
      tcap_d[i] = tcap_q[i];
`endif
      // a release and a new strobe in the same cycle refill the register
      full_d[i] = full_q[i] & ~(rel_last && g_q == 3'(i));
      if (ch_valid[i] && !full_d[i]) begin
        full_d[i] = 1'b1;
        x_d[i] = ch_x[16*i +: 16];
        y_d[i] = ch_y[16*i +: 16];
`ifdef LIA_LOG_TSTAMP_EN
        tcap_d[i] = ts_q;
`endif
      end else if (ch_valid[i]) ndrop = ndrop + 4'd1;
      if (clr) full_d[i] = 1'b0;
    end
    ovf_sum = {1'b0, ovf_q} + {13'd0, ndrop};
    ovf_d = clr ? '0 : ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
`ifdef LIA_LOG_TSTAMP_EN
    ts_d = clr ? '0 : ts_q + 16'd1;
    word = widx_q == 2'd0 ? {1'b1, g_q, seq_q} : widx_q == 2'd1 ? x_q[g_q] :
           widx_q == 2'd2 ? y_q[g_q] : tcap_q[g_q];
`else
    word = widx_q == 2'd0 ? {1'b1, g_q, seq_q} : widx_q == 2'd1 ? x_q[g_q] : y_q[g_q];
`endif
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      full_q <= '0;
      last_q <= 3'd7;
      g_q <= '0;
      widx_q <= '0;
      cnt_q <= '0;
      seq_q <= '0;
      ptr_q <= '0;
      wrap_q <= 1'b0;
      clrp_q <= 1'b0;
      ovf_q <= '0;
      for (int i = 0; i < 8; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      last_q <= last_d;
      g_q <= g_d;
      widx_q <= widx_d;
      cnt_q <= cnt_d;
      seq_q <= seq_d;
      ptr_q <= ptr_d;
      wrap_q <= wrap_d;
      clrp_q <= clrp_d;
      ovf_q <= ovf_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
`ifdef LIA_LOG_TSTAMP_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ts_q <= '0;
      for (int i = 0; i < 8; i++) tcap_q[i] <= '0;
    end else begin
      ts_q <= ts_d;
      tcap_q <= tcap_d;
    end
  end
`endif
  assign busy = state_q != IDLE;
  assign sram.addr = busy ? ptr_q : '0;
  assign sram.dq_out = busy ? word : '0;
  assign sram.dq_oe = busy;
  assign sram.ce_n = ~busy;
  assign sram.we_n = state_q != PULSE;
  assign sram.oe_n = 1'b1;
  assign sram.lb_n = ~busy;
  assign sram.ub_n = ~busy;
  assign wr_ptr = ptr_q;
  assign wrapped = wrap_q;
  assign overflow_count = ovf_q;
endmodule

// File: doc/lia_sram_logger.md
LIA_SRAM_LOGGER -- requirements
Module: lia_sram_logger

Interface
REQ-001 Parameter DEPTH_WORDS, default 1048560, SHALL set the word count of the SRAM log ring; it must be a multiple of the record length.
REQ-002 Parameter WE_CYCLES, default 2, SHALL set the WE_N low-pulse width in clocks; range 1-15.
REQ-003 clk_clk  input  1  SHALL be the single system clock.
REQ-004 reset_reset_n  input  1  SHALL be the reset; asynchronous, active-low.
REQ-005 ch_valid  input  8  SHALL carry one-cycle sample strobes, one bit per lock-in channel 0-7.
REQ-006 ch_x, ch_y  input  128 each  SHALL carry channel n's signed 16-bit X/Y result in bits [16n+15:16n].
REQ-007 log_enable  input  1  SHALL, when high, permit new record writes.
REQ-008 log_clear  input  1  SHALL be a one-cycle request to rewind the log.
REQ-009 sram_addr  output  20  SHALL be the SRAM word address.
REQ-010 sram_dq_out  output  16  SHALL be the write data; sram_dq_oe  output  1  SHALL enable the external DQ tristate.
REQ-011 sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n  outputs  1 each  SHALL be the SRAM strobes, all active-low.
REQ-012 wr_ptr  output  20  SHALL be the next word address to write.
REQ-013 wrapped  output  1  SHALL be a sticky flag set when wr_ptr wraps to 0.
REQ-014 overflow_count  output  16  SHALL count dropped samples, saturating at 16'hFFFF.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 Each channel SHALL have a one-deep holding register (X, Y, full flag) loaded on ch_valid when empty.
REQ-017 A ch_valid arriving while that channel's register is full SHALL be dropped (register unchanged) and SHALL increment overflow_count.
REQ-018 A ch_valid arriving in the same cycle the register is released SHALL be captured, not dropped.
REQ-019 Arbitration SHALL be round-robin over full registers, searching from the channel after the last grant; after reset the search starts at channel 0.
REQ-020 FSM states SHALL be IDLE, SETUP, PULSE, HOLD; IDLE->SETUP when log_enable is high and any register is full, with the grant latched in that cycle.
REQ-021 A record SHALL be the word sequence: tag {1'b1, ch[2:0], seq[11:0]}, X, Y; seq is a 12-bit per-module counter incremented per record, wrapping 4095->0.
REQ-022 Per word: SETUP 1 cycle (addr/data driven, CE_N=0, DQ_OE=1, WE_N=1); PULSE WE_CYCLES cycles (WE_N=0); HOLD 1 cycle (WE_N=1, addr/data stable).
REQ-023 HOLD SHALL go to SETUP for the next word of the record, or to IDLE after the last word; the granted register SHALL be released in that last HOLD cycle.
REQ-024 wr_ptr SHALL increment by 1 after each word's HOLD and wrap DEPTH_WORDS-1 -> 0, setting wrapped.
REQ-025 sram_oe_n SHALL stay 1, and sram_lb_n and sram_ub_n SHALL be 0 during writes; CE_N SHALL be 1 and DQ_OE 0 in IDLE.
REQ-026 Deasserting log_enable mid-record SHALL NOT abort it; no new record SHALL start until log_enable is high.
REQ-027 log_clear in IDLE SHALL, the next cycle, zero wr_ptr, wrapped, seq and overflow_count, and empty all registers.
REQ-028 log_clear while busy SHALL be latched and applied on return to IDLE, before any new grant.
REQ-029 Record latency SHALL be 1 + W*(2+WE_CYCLES) cycles from the IDLE grant, where W is the number of words per record.

Reset
REQ-030 Asserting reset_reset_n low SHALL immediately force: CE_N/WE_N/OE_N=1, LB_N/UB_N=1, DQ_OE=0, sram_addr=0, sram_dq_out=0, FSM=IDLE, busy=0.
REQ-031 Reset SHALL clear wr_ptr, wrapped, seq, overflow_count, all full flags, and the pending clear; round-robin pointer = channel 7, so the first search starts at 0.
REQ-032 Reset mid-PULSE SHALL end the write immediately with no partial-state recovery.

Configuration
REQ-033 With LIA_LOG_TSTAMP_EN defined, a free-running 16-bit cycle counter SHALL be captured per register on load and written as a 4th word after Y (W=4); the counter SHALL be reset by reset and log_clear.
REQ-034 Without LIA_LOG_TSTAMP_EN, records SHALL be 3 words and no counter logic SHALL exist.

Verification
REQ-035 Reset, enable=1, ch3 strobe X=16'h1234 Y=16'hFEDC -> writes at 0,1,2: 16'hB000, 16'h1234, 16'hFEDC; wr_ptr=3; WE_N low for exactly 2 cycles per word.
REQ-036 All 8 ch_valid pulsed in the same cycle -> records in order ch0..ch7, seq 0..7, wr_ptr=24, overflow_count=0.
REQ-037 ch5 strobed twice while its record is pending -> overflow_count=1; the second value is never written.
REQ-038 DEPTH_WORDS=6, three ch0 records -> the third record is written at 0-2, wrapped=1.
REQ-039 log_clear pulsed during a word's PULSE state -> the record completes, then wr_ptr=0, seq=0, wrapped=0.
REQ-040 reset_reset_n asserted while WE_N=0 -> WE_N=1 and DQ_OE=0 in the same cycle; the next record after release starts at address 0.
